hazard_controller: RTL and testbench
====================================

Name: hazard_controller

Overview:
Pipeline interlock and sequencing controller for the in-order 5-stage core (IF, ID, EX, MA, WB). It consumes the decoded control-word fields of the instruction in ID (register usage, writeback, CSR, halt) and tracks in-flight destinations in EX/MA/WB. From these it produces the ID stall, the ID squash, and the registered EX-operand forwarding selects. It also sequences a decoded halt into a drained, sticky halted state.

Parameters:
- REG_ADDR_W, 5, register address width.
- CSR_SERIALIZE, 1, when 1 a CSR-using instruction waits in ID until EX/MA/WB hold no valid instruction.

Ports:
- clk_i  in  1  core clock
- reset_i  in  1  synchronous, active-high reset
- id_valid_i  in  1  ID holds a real instruction
- id_ra_addr_i  in  5  rs1 address
- id_ra_used_i  in  1  rs1 read (already masked for x0)
- id_rb_addr_i  in  5  rs2 address
- id_rb_used_i  in  1  rs2 read (already masked for x0)
- id_wb_addr_i  in  5  rd address
- id_wb_valid_i  in  1  instruction writes rd (already masked for x0)
- id_wb_from_mem_i  in  1  writeback source is memory (load)
- id_csr_used_i  in  1  CSR instruction
- id_halt_i  in  1  decoder halt / illegal instruction
- ex_redirect_i  in  1  taken branch or jump resolved in EX this cycle
- id_stall_o  out  1  hold IF/ID this cycle (combinational)
- id_flush_o  out  1  squash the ID instruction; a bubble enters EX (combinational)
- ex_fwd_a_o  out  2  rs1 operand source for the instruction now in EX (registered)
- ex_fwd_b_o  out  2  rs2 operand source for the instruction now in EX (registered)
- halted_o  out  1  core halted, sticky (registered)

Behaviour:
- Tracking: three-entry shift register, EX to MA to WB. Each entry is {valid, rd, from_mem}. It shifts every cycle. The next EX entry is the ID instruction when id_valid_i & ~id_stall_o & ~id_flush_o & id_wb_valid_i; otherwise it is a bubble (valid=0).
- A producer in an entry only matters when rd != 0.
- Load-use stall: ID rs1 or rs2 is used and matches the EX entry rd, and that entry has from_mem=1. This stalls for exactly 1 cycle.
- CSR stall: applies when CSR_SERIALIZE=1, id_csr_used_i=1, and any tracking entry is valid.
- id_stall_o = id_valid_i & (load-use | CSR stall | state != RUN) & ~ex_redirect_i.
- id_flush_o = ex_redirect_i. The redirect has priority over every stall.
- Forwarding select codes: 0 = register file, 1 = EX result (producer now in EX), 2 = MA result (producer in MA), 3 = WB value (producer in WB).
  - Select is computed in ID per operand; the youngest matching producer wins (EX > MA > WB).
  - Unused operand → 0.
  - Registered into ex_fwd_*_o when the ID instruction advances. On bubble/stall/flush the register loads 0.
  - Latency: 1 cycle, aligned with the instruction entering EX.
- FSM states:
  - RUN: ID instruction with id_halt_i=1, id_valid_i=1, no load-use/CSR stall, and no redirect → go to DRAIN. The halting instruction does not enter EX.
  - DRAIN: ID is stalled. If ex_redirect_i=1 (an older branch is leaving), the halt was speculative → RUN, with ID flushed. If all tracking entries are invalid and there is no redirect → HALTED.
  - HALTED: id_stall_o=1 whenever id_valid_i; halted_o=1. Exit only by reset_i.
- Reset, synchronous, overrides everything in that cycle:
  - tracking entries invalid, state RUN
  - ex_fwd_a_o = ex_fwd_b_o = 0, halted_o = 0
  - id_stall_o/id_flush_o follow their combinational inputs with empty tracking.
- Simultaneous events:
  - redirect plus load-use → flush, no stall.
  - halt plus redirect in RUN → flush, stay in RUN.
  - rs1 == rs2 == the same producer → both selects are identical.
- A stalled ID instruction re-evaluates its hazards every cycle as producers advance. Its forwarding select reflects the producer's position in the cycle it finally advances.

Test Plan:
- Back-to-back ALU ops `addi x5,x0,1 ; add x6,x5,x5`, no stall → in the cycle the add is in EX, ex_fwd_a_o=1 and ex_fwd_b_o=1.
- Load-use `lw x7,0(x1) ; add x8,x7,x0` → id_stall_o=1 for exactly 1 cycle, then the add enters EX with ex_fwd_a_o=2 and ex_fwd_b_o=0.
- Producer 3 instructions ahead, `addi x9,...; nop; nop; sub x10,x9,x9` → ex_fwd_a_o=3; with 4 ahead → 0. Writes to x0 never forward.
- CSR serialize: csrrw behind an ALU op in EX → stall cycles until EX/MA/WB are empty (3 cycles), then it advances; ex_redirect_i during the stall → id_flush_o=1, id_stall_o=0.
- Halt: illegal instruction following a store → DRAIN, halted_o=1 after 3 cycles and sticky; repeat with ex_redirect_i=1 in the first DRAIN cycle → back to RUN, halted_o stays 0.
- reset_i asserted in DRAIN with entries valid → next cycle: state RUN, all outputs 0, no stale forwarding.

Source files
------------

// File: rtl/hazard_controller.sv
// ID-stage interlock controller: load-use and CSR stalls, redirect squash,
// registered EX forwarding selects and a halt drain/halted sequencer.
module hazard_controller #(
  parameter int REG_ADDR_W    = 5,
  parameter bit CSR_SERIALIZE = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_ra_addr_i,
  input  logic                  id_ra_used_i,
  input  logic [REG_ADDR_W-1:0] id_rb_addr_i,
  input  logic                  id_rb_used_i,
  input  logic [REG_ADDR_W-1:0] id_wb_addr_i,
  input  logic                  id_wb_valid_i,
  input  logic                  id_wb_from_mem_i,
  input  logic                  id_csr_used_i,
  input  logic                  id_halt_i,
  input  logic                  ex_redirect_i,
  output logic                  id_stall_o,
  output logic                  id_flush_o,
  output logic [1:0]            ex_fwd_a_o,
  output logic [1:0]            ex_fwd_b_o,
  output logic                  halted_o
);

  typedef struct packed {
    logic                  vld;
    logic [REG_ADDR_W-1:0] rd;
    logic                  mem;
  } trk_t;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_e;

  trk_t   ex_q, ma_q, wb_q, ex_d;
  state_e state_q, state_d;
  logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic load_use, csr_stall, any_vld, advance;

  function automatic logic hit(input trk_t e, input logic [REG_ADDR_W-1:0] a);
    return e.vld && (e.rd != '0) && (e.rd == a);
  endfunction

  // Youngest producer wins: EX, then MA, then WB.
  function automatic logic [1:0] fsel(input logic used, input logic [REG_ADDR_W-1:0] a,
                                      input trk_t ex, input trk_t ma, input trk_t wb);
    if (!used)         return 2'd0;
    else if (hit(ex, a)) return 2'd1;
    else if (hit(ma, a)) return 2'd2;
    else if (hit(wb, a)) return 2'd3;
    else               return 2'd0;
  endfunction

  always_comb begin
    load_use  = ex_q.mem & ((id_ra_used_i & hit(ex_q, id_ra_addr_i)) |
                            (id_rb_used_i & hit(ex_q, id_rb_addr_i)));
    any_vld   = ex_q.vld | ma_q.vld | wb_q.vld;
    csr_stall = CSR_SERIALIZE & id_csr_used_i & any_vld;
    id_stall_o = id_valid_i & (load_use | csr_stall | (state_q != RUN)) & ~ex_redirect_i;
    id_flush_o = ex_redirect_i;
    // A halting instruction leaves ID but never occupies EX.
    advance = id_valid_i & ~id_stall_o & ~id_flush_o & ~id_halt_i;
    ex_d    = '0;
    if (advance && id_wb_valid_i) ex_d = '{vld: 1'b1, rd: id_wb_addr_i, mem: id_wb_from_mem_i};
    fwd_a_d = advance ? fsel(id_ra_used_i, id_ra_addr_i, ex_q, ma_q, wb_q) : 2'd0;
    fwd_b_d = advance ? fsel(id_rb_used_i, id_rb_addr_i, ex_q, ma_q, wb_q) : 2'd0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:
        if (id_valid_i && id_halt_i && !load_use && !csr_stall && !ex_redirect_i)
          state_d = DRAIN;
      DRAIN:
        if (ex_redirect_i) state_d = RUN;
        else if (!any_vld) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ex_q    <= '0;
      ma_q    <= '0;
      wb_q    <= '0;
      fwd_a_q <= 2'd0;
      fwd_b_q <= 2'd0;
      state_q <= RUN;
    end else begin
      ex_q    <= ex_d;
      ma_q    <= ex_q;
      wb_q    <= ma_q;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      state_q <= state_d;
    end
  end

  assign ex_fwd_a_o = fwd_a_q;
  assign ex_fwd_b_o = fwd_b_q;
  assign halted_o   = (state_q == HALTED);

endmodule

// File: tb/tb_hazard_controller.sv
// Directed scenario bench for hazard_controller with hand-derived expectations.
module tb_hazard_controller;
  logic clk = 1'b0, reset;
  logic id_valid, ra_used, rb_used, wb_valid, wb_mem, csr_used, halt, redirect;
  logic [4:0] ra, rb, wb;
  logic stall, flush, halted;
  logic [1:0] fa, fb;
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  hazard_controller dut (
    .clk_i(clk), .reset_i(reset), .id_valid_i(id_valid),
    .id_ra_addr_i(ra), .id_ra_used_i(ra_used), .id_rb_addr_i(rb), .id_rb_used_i(rb_used),
    .id_wb_addr_i(wb), .id_wb_valid_i(wb_valid), .id_wb_from_mem_i(wb_mem),
    .id_csr_used_i(csr_used), .id_halt_i(halt), .ex_redirect_i(redirect),
    .id_stall_o(stall), .id_flush_o(flush), .ex_fwd_a_o(fa), .ex_fwd_b_o(fb),
    .halted_o(halted)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    id_valid = 0; ra = 0; ra_used = 0; rb = 0; rb_used = 0;
    wb = 0; wb_valid = 0; wb_mem = 0; csr_used = 0; halt = 0; redirect = 0;
  endtask

  task automatic instr(input logic [4:0] a, input logic au, input logic [4:0] b, input logic bu,
                       input logic [4:0] d, input logic dv, input logic mem,
                       input logic csr, input logic h);
    id_valid = 1; ra = a; ra_used = au; rb = b; rb_used = bu;
    wb = d; wb_valid = dv; wb_mem = mem; csr_used = csr; halt = h; redirect = 0;
  endtask

  task automatic drain();
    idle(); repeat (3) step();
  endtask

  task automatic test_reset();
    idle(); #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b want 0", stall); end
    n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL reset_flush got %b want 0", flush); end
    n_cmp++; if (fa !== 2'd0 || fb !== 2'd0) begin n_err++; $display("FAIL reset_fwd got %0d/%0d want 0/0", fa, fb); end
    n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted got %b want 0", halted); end
  endtask

  task automatic test_back_to_back();
    instr(0, 0, 0, 0, 5, 1, 0, 0, 0); step();          // addi x5
    instr(5, 1, 5, 1, 6, 1, 0, 0, 0); #1;              // add x6,x5,x5
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL b2b_stall got %b want 0", stall); end
    step();
    n_cmp++; if (fa !== 2'd1 || fb !== 2'd1) begin n_err++; $display("FAIL b2b_fwd got %0d/%0d want 1/1", fa, fb); end
    drain();
  endtask

  task automatic test_load_use();
    instr(1, 1, 0, 0, 7, 1, 1, 0, 0); step();          // lw x7,0(x1)
    instr(7, 1, 0, 0, 8, 1, 0, 0, 0); #1;              // add x8,x7,x0
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL lu_stall1 got %b want 1", stall); end
    step();
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL lu_stall2 got %b want 0", stall); end
    n_cmp++; if (fa !== 2'd0) begin n_err++; $display("FAIL lu_bubble_fwd got %0d want 0", fa); end
    step();
    n_cmp++; if (fa !== 2'd2 || fb !== 2'd0) begin n_err++; $display("FAIL lu_fwd got %0d/%0d want 2/0", fa, fb); end
    drain();
    // redirect together with load-use: flush wins, no stall
    instr(1, 1, 0, 0, 7, 1, 1, 0, 0); step();
    instr(7, 1, 0, 0, 8, 1, 0, 0, 0); redirect = 1; #1;
    n_cmp++; if (flush !== 1'b1 || stall !== 1'b0) begin n_err++; $display("FAIL lu_redir got f%b s%b want f1 s0", flush, stall); end
    step();
    n_cmp++; if (fa !== 2'd0) begin n_err++; $display("FAIL lu_redir_fwd got %0d want 0", fa); end
    drain();
  endtask

  task automatic test_fwd_distance();
    instr(0, 0, 0, 0, 9, 1, 0, 0, 0); step();          // addi x9
    instr(0, 0, 0, 0, 0, 0, 0, 0, 0); step(); step();  // nop; nop
    instr(9, 1, 9, 1, 10, 1, 0, 0, 0); step();         // sub x10,x9,x9
    n_cmp++; if (fa !== 2'd3 || fb !== 2'd3) begin n_err++; $display("FAIL dist3_fwd got %0d/%0d want 3/3", fa, fb); end
    drain();
    instr(0, 0, 0, 0, 9, 1, 0, 0, 0); step();
    instr(0, 0, 0, 0, 0, 0, 0, 0, 0); step(); step(); step();
    instr(9, 1, 0, 0, 10, 1, 0, 0, 0); step();
    n_cmp++; if (fa !== 2'd0) begin n_err++; $display("FAIL dist4_fwd got %0d want 0", fa); end
    drain();
    // producer naming x0 (load) must neither stall nor forward
    instr(0, 0, 0, 0, 0, 1, 1, 0, 0); step();
    instr(0, 1, 0, 1, 3, 1, 0, 0, 0); #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL x0_stall got %b want 0", stall); end
    step();
    n_cmp++; if (fa !== 2'd0 || fb !== 2'd0) begin n_err++; $display("FAIL x0_fwd got %0d/%0d want 0/0", fa, fb); end
    drain();
  endtask

  task automatic test_csr();
    instr(0, 0, 0, 0, 11, 1, 0, 0, 0); step();         // addi x11
    instr(11, 1, 0, 0, 12, 1, 0, 1, 0);                // csrrw x12, csr, x11
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL csr_stall%0d got %b want 1", i, stall); end
      step();
    end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL csr_release got %b want 0", stall); end
    step();
    n_cmp++; if (fa !== 2'd0) begin n_err++; $display("FAIL csr_fwd got %0d want 0", fa); end
    drain();
    instr(0, 0, 0, 0, 11, 1, 0, 0, 0); step();
    instr(11, 1, 0, 0, 12, 1, 0, 1, 0); #1;
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL csr2_stall got %b want 1", stall); end
    redirect = 1; #1;
    n_cmp++; if (flush !== 1'b1 || stall !== 1'b0) begin n_err++; $display("FAIL csr_redir got f%b s%b want f1 s0", flush, stall); end
    drain();
  endtask

  task automatic test_halt();
    instr(1, 1, 2, 1, 0, 0, 0, 0, 0); step();          // sw
    instr(0, 0, 0, 0, 0, 0, 0, 0, 1); #1;              // illegal
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL halt_run_stall got %b want 0", stall); end
    step();                                            // DRAIN, entries already empty
    instr(0, 0, 0, 0, 4, 1, 0, 0, 0); #1;
    n_cmp++; if (stall !== 1'b1 || halted !== 1'b0) begin n_err++; $display("FAIL drain got s%b h%b want s1 h0", stall, halted); end
    step();
    n_cmp++; if (halted !== 1'b1 || stall !== 1'b1) begin n_err++; $display("FAIL halted got h%b s%b want h1 s1", halted, stall); end
    repeat (3) step();
    n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL halted_sticky got %b want 1", halted); end
    reset = 1; step(); reset = 0; #1;
    n_cmp++; if (halted !== 1'b0 || stall !== 1'b0) begin n_err++; $display("FAIL halt_reset got h%b s%b want h0 s0", halted, stall); end
    drain();
    // halt behind a writer waits for it to leave WB
    instr(0, 0, 0, 0, 3, 1, 0, 0, 0); step();
    instr(0, 0, 0, 0, 0, 0, 0, 0, 1); step();
    idle();
    step(); step();
    n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL halt_wait got %b want 0", halted); end
    step();
    n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL halt_after_drain got %b want 1", halted); end
    reset = 1; step(); reset = 0;
    // redirect in first DRAIN cycle cancels the halt
    instr(1, 1, 2, 1, 0, 0, 0, 0, 0); step();
    instr(0, 0, 0, 0, 0, 0, 0, 0, 1); step();
    instr(0, 0, 0, 0, 4, 1, 0, 0, 0); redirect = 1; #1;
    n_cmp++; if (flush !== 1'b1 || stall !== 1'b0) begin n_err++; $display("FAIL drain_redir got f%b s%b want f1 s0", flush, stall); end
    step(); redirect = 0; #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL back_to_run got %b want 0", stall); end
    step(); step();
    n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL spec_halt got %b want 0", halted); end
    // halt with redirect in RUN: flush, stay in RUN
    instr(0, 0, 0, 0, 0, 0, 0, 0, 1); redirect = 1; #1;
    n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL halt_redir_flush got %b want 1", flush); end
    step();
    instr(0, 0, 0, 0, 4, 1, 0, 0, 0); #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL halt_redir_run got %b want 0", stall); end
    drain();
  endtask

  task automatic test_reset_in_drain();
    instr(0, 0, 0, 0, 12, 1, 0, 0, 0); step();
    instr(0, 0, 0, 0, 13, 1, 0, 0, 0); step();
    instr(0, 0, 0, 0, 0, 0, 0, 0, 1); step();          // DRAIN with MA/WB valid
    instr(13, 1, 12, 1, 14, 1, 0, 0, 0); #1;
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL rd_drain_stall got %b want 1", stall); end
    reset = 1; step(); reset = 0; #1;
    n_cmp++; if (stall !== 1'b0 || halted !== 1'b0) begin n_err++; $display("FAIL rd_state got s%b h%b want s0 h0", stall, halted); end
    n_cmp++; if (fa !== 2'd0 || fb !== 2'd0) begin n_err++; $display("FAIL rd_fwd got %0d/%0d want 0/0", fa, fb); end
    step();
    n_cmp++; if (fa !== 2'd0 || fb !== 2'd0) begin n_err++; $display("FAIL rd_stale got %0d/%0d want 0/0", fa, fb); end
    drain();
  endtask

  initial begin
    reset = 1; idle();
    repeat (2) @(posedge clk);
    #1 reset = 0;
    test_reset();
    test_back_to_back();
    test_load_use();
    test_fwd_distance();
    test_csr();
    test_halt();
    test_reset_in_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
